// File: rtl/stack_if.sv
// Handshake and data bundle between a stack requester and stack_ctrl.
// The requester drives the op fields; the controller returns status and popped data.
interface stack_if #(
    parameter int WIDTH = 32
);
    logic [2:0]       StackOp;
    logic             start;
    logic [WIDTH-1:0] regval;
    logic [WIDTH-1:0] PCin;
    logic [WIDTH-1:0] LMD;
    logic             done;
    logic             busy;
    logic [WIDTH-1:0] SP;
    logic             overflow;
    logic             underflow;

    modport master (
        output StackOp, start, regval, PCin,
        input  LMD, done, busy, SP, overflow, underflow
    );

    modport slave (
        input  StackOp, start, regval, PCin,
        output LMD, done, busy, SP, overflow, underflow
    );
endinterface

// File: rtl/stack_ctrl.sv
// Descending hardware stack for PUSH/POP/CALL/RET with a three-state op sequencer.
// SP == DEPTH is empty, SP == 0 is full; overflow/underflow are sticky until reset.
module stack_ctrl #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic   clk,
    input  logic   rst,
    stack_if.slave bus
);
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SPW = AW + 1;
    localparam logic [SPW-1:0] SP_EMPTY = SPW'(DEPTH);
    localparam logic [SPW-1:0] SP_FULL  = '0;

    localparam logic [2:0] OP_PUSH = 3'b001;
    localparam logic [2:0] OP_POP  = 3'b010;
    localparam logic [2:0] OP_CALL = 3'b011;
    localparam logic [2:0] OP_RET  = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_regval;
    logic [WIDTH-1:0] r_pc;
    logic [SPW-1:0]   r_sp;
    logic [WIDTH-1:0] r_lmd;
    logic             r_overflow;
    logic             r_underflow;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic             w_op_valid;
    logic             w_accept;
    logic             w_exec;
    logic             w_busy;
    logic             w_done;
    logic             w_is_push;
    logic             w_is_pop;
    logic             w_full;
    logic             w_empty;
    logic             w_do_push;
    logic             w_do_pop;
    logic [AW-1:0]    w_wr_addr;
    logic [AW-1:0]    w_rd_addr;
    logic [WIDTH-1:0] w_wdata;

    assign w_op_valid = (bus.StackOp == OP_PUSH) || (bus.StackOp == OP_POP) ||
                        (bus.StackOp == OP_CALL) || (bus.StackOp == OP_RET);
    assign w_accept   = (r_state == S_IDLE) && bus.start && w_op_valid;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_EXEC;
            S_EXEC:  w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        w_exec = 1'b0;
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            S_EXEC: begin
                w_exec = 1'b1;
                w_busy = 1'b1;
            end
            S_DONE: begin
                w_busy = 1'b1;
                w_done = 1'b1;
            end
            default: ;
        endcase
    end

    // Op fields are latched once so input changes during EXEC cannot disturb the op
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_op     <= bus.StackOp;
            r_regval <= bus.regval;
            r_pc     <= bus.PCin;
        end
    end

    assign w_is_push = (r_op == OP_PUSH) || (r_op == OP_CALL);
    assign w_is_pop  = (r_op == OP_POP)  || (r_op == OP_RET);
    assign w_full    = (r_sp == SP_FULL);
    assign w_empty   = (r_sp == SP_EMPTY);
    assign w_do_push = w_exec && w_is_push && !w_full;
    assign w_do_pop  = w_exec && w_is_pop  && !w_empty;
    // Low AW bits minus one maps SP=DEPTH onto the top slot without a wider subtract
    assign w_wr_addr = r_sp[AW-1:0] - AW'(1);
    assign w_rd_addr = r_sp[AW-1:0];
    assign w_wdata   = (r_op == OP_CALL) ? (r_pc + WIDTH'(1)) : r_regval;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sp        <= SP_EMPTY;
            r_lmd       <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_do_push) begin
                r_sp <= r_sp - SPW'(1);
            end
            if (w_do_pop) begin
                r_sp  <= r_sp + SPW'(1);
                r_lmd <= r_mem[w_rd_addr];
            end
            if (w_exec && w_is_push && w_full) begin
                r_overflow <= 1'b1;
            end
            if (w_exec && w_is_pop && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    // Storage is not reset; a reset coinciding with EXEC also drops the write
    always_ff @(posedge clk) begin
        if (!rst && w_do_push) begin
            r_mem[w_wr_addr] <= w_wdata;
        end
    end

    assign bus.LMD       = r_lmd;
    assign bus.done      = w_done;
    assign bus.busy      = w_busy;
    assign bus.SP        = WIDTH'(r_sp);
    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;
endmodule

// File: doc/stack_ctrl.md
STACK_CTRL -- requirements
Module: stack_ctrl

Interface
REQ-001 Parameter DEPTH, default 16, number of 32-bit stack entries; power of two, 2..256.
REQ-002 Parameter WIDTH, default 32, data and address width.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 StackOp  input  3  001 PUSH, 010 POP, 011 CALL, 100 RET, any other value is NOP.
REQ-006 start  input  1  op request; sampled only when busy=0.
REQ-007 regval  input  WIDTH  data pushed by PUSH.
REQ-008 PCin  input  WIDTH  current PC; CALL pushes PCin+1.
REQ-009 LMD  output  WIDTH  last value popped by POP/RET; PC redirect source for RET.
REQ-010 done  output  1  one-cycle pulse marking op completion.
REQ-011 busy  output  1  high from the cycle after an accepted start through the done cycle.
REQ-012 SP  output  WIDTH  stack pointer (entry index), zero-extended.
REQ-013 overflow  output  1  sticky; set by PUSH/CALL on a full stack.
REQ-014 underflow  output  1  sticky; set by POP/RET on an empty stack.

Function
REQ-015 Descending stack: SP=DEPTH means empty, SP=0 means full; occupancy = DEPTH-SP.
REQ-016 FSM states IDLE, EXEC, DONE; IDLE->EXEC on start=1 with a non-NOP StackOp; EXEC->DONE unconditionally; DONE->IDLE unconditionally.
REQ-017 start with a NOP StackOp in IDLE: no state change, no done pulse.
REQ-018 start while busy=1 is ignored; no queuing.
REQ-019 StackOp, regval and PCin are captured on the accepting edge; later input changes do not affect the op.
REQ-020 PUSH in EXEC, not full: SP<=SP-1, mem[SP-1]<=captured regval.
REQ-021 CALL in EXEC, not full: SP<=SP-1, mem[SP-1]<=captured PCin+1, mod 2^WIDTH.
REQ-022 POP/RET in EXEC, not empty: LMD<=mem[SP], SP<=SP+1.
REQ-023 PUSH/CALL when full: no write, SP unchanged, overflow<=1.
REQ-024 POP/RET when empty: LMD unchanged, SP unchanged, underflow<=1.
REQ-025 done=1 only in DONE: exactly one cycle, 2 cycles after the accepting edge; also pulses on overflow/underflow.
REQ-026 LMD holds its value until the next successful POP/RET.
REQ-027 SP never wraps: stays within 0..DEPTH in all cases.
REQ-028 busy=1 in EXEC and DONE, 0 in IDLE; new start accepted the cycle after done.
REQ-029 Memory is a synchronous-write, DEPTH x WIDTH array; contents are not reset.

Reset
REQ-030 rst=1 at an edge: state<=IDLE, SP<=DEPTH, LMD<=0, done<=0, busy<=0, overflow<=0, underflow<=0.
REQ-031 rst mid-op (EXEC or DONE): op aborted, no done pulse, SP reset regardless of a pending write.
REQ-032 rst takes priority over start in the same cycle.
REQ-033 Sticky flags clear only on rst.

Verification
REQ-034 After reset, PUSH regval=0xA5 -> done at cycle +2, SP=15; then POP -> LMD=0xA5, SP=16, flags 0.
REQ-035 CALL PCin=0x40, then RET -> LMD=0x41, SP back to 16, done pulse per op.
REQ-036 16 PUSHes of 1..16, then a 17th PUSH -> SP=0, overflow=1, mem unchanged; 16 POPs return 16..1 in order.
REQ-037 POP on empty -> underflow=1, LMD unchanged, SP=16, done pulses once.
REQ-038 start held high for 4 cycles with PUSH -> two pushes accepted (cycles 0 and 3), SP=14.
REQ-039 rst asserted in EXEC of a PUSH -> no done, SP=16, busy=0 next cycle, flags 0.
